pmp_check_arbiter: RTL and testbench
====================================

// Module: pmp_check_arbiter
// PURPOSE
//  Shares one PMP checker (built around the 2-way PMP selector) between two requesters:
//  port 0 = ITLB miss path, port 1 = DTLB miss path.
//  Round-robin arbitration, one check in flight, result routed back to the granted port.
//  Synchronous controller in front of the self-timed PMP pipeline.
// PARAMETERS
//  PADDR_W      34  physical address width, in bits
//  TIMEOUT_CYC  64  WAIT-state cycle limit; used only when PMP_ARB_TIMEOUT_EN is defined
// PORTS
//  clk              in   1        clock
//  rstn             in   1        asynchronous reset, active low
//  req0_valid       in   1        port 0 check request
//  req0_ready       out  1        port 0 request accepted
//  req0_addr        in   PADDR_W  port 0 physical address
//  req0_type        in   2        port 0 access type: 00 = R, 01 = W, 10 = X, 11 = reserved
//  req1_valid/ready/addr/type     same as port 0, for port 1
//  rsp0_valid       out  1        port 0 result valid
//  rsp0_ready       in   1        port 0 result taken
//  rsp0_fault       out  1        port 0 access fault
//  rsp1_valid/ready/fault         same as port 0, for port 1
//  chk_req_valid    out  1        request to the PMP checker
//  chk_req_ready    in   1        checker accepted the request
//  chk_addr         out  PADDR_W  registered address
//  chk_type         out  2        registered access type
//  chk_resp_valid   in   1        checker result, one-cycle pulse
//  chk_resp_fault   in   1        fault flag; qualified by chk_resp_valid
//  timeout_err      out  1        sticky timeout flag
// BEHAVIOUR
//  - Reset (rstn low, async): state = IDLE, rr_ptr = 0, all valid/ready outputs = 0,
//    chk_addr = 0, chk_type = 0, timeout_err = 0, stored owner/fault = 0.
//  - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - Grant (IDLE only), combinational:
//    - Only one valid requester: that port is granted.
//    - Both valid: grant port rr_ptr.
//    - reqN_ready = (state == IDLE) & grantN. At most one ready is high per cycle.
//  - Accept (IDLE, reqN_valid & reqN_ready):
//    - Register addr/type into chk_addr/chk_type; owner = N; rr_ptr <= ~N.
//    - Next state ISSUE.
//  - ISSUE:
//    - chk_req_valid = 1, chk_addr/chk_type held stable.
//    - Leave for WAIT on the cycle chk_req_ready = 1.
//  - WAIT:
//    - chk_resp_valid is sampled only in WAIT; pulses in any other state are ignored.
//    - On chk_resp_valid: latch chk_resp_fault; next state RESP.
//  - RESP:
//    - rsp<owner>_valid = 1 and rsp<owner>_fault = latched fault, held until rsp<owner>_ready.
//    - The other port's rsp_valid stays 0.
//    - On handshake: next state IDLE.
//  - Latency: accept at cycle T; chk_req_valid from T+1. Minimum (checker ready at T+1,
//    response at T+2): rsp valid at T+3, next accept at T+4 at the earliest.
//  - Requests arriving outside IDLE stall: reqN_ready = 0, and the requester holds its
//    request stable.
//  - rr_ptr changes only on accept, so a lone requester can be granted back-to-back.
//  - Port-1 address and type changing while not ready have no effect.
//  - Reset mid-operation: any in-flight check is abandoned. A checker response after reset
//    is dropped because the state is IDLE.
// CONFIGURATION
//  - PMP_ARB_TIMEOUT_EN defined:
//    - An 8-bit wait_cnt clears on WAIT entry and increments each WAIT cycle.
//    - When wait_cnt == TIMEOUT_CYC-1 without chk_resp_valid: fault = 1, go to RESP,
//      set timeout_err. timeout_err stays set until reset.
//    - chk_resp_valid in that same cycle takes priority: normal result, no error.
//  - PMP_ARB_TIMEOUT_EN not defined:
//    - WAIT has no cycle limit, no counter is built, and timeout_err is tied 0.
// TESTING
//  1. Reset with both reqs valid -> all outputs 0; after release, req0_ready = 1 in the
//     first cycle (rr_ptr = 0).
//  2. Only req1, addr 0x80001000, type R; checker ready at once, responds next cycle with
//     fault = 0 -> rsp1_valid = 1 and rsp1_fault = 0 three cycles after accept;
//     rsp0_valid stays 0.
//  3. Both ports valid continuously for 4 checks -> grant order 0, 1, 0, 1; chk_addr
//     matches the granted port each time.
//  4. Port 0, type W, checker returns fault = 1; rsp0_ready held low 5 cycles ->
//     rsp0_valid and rsp0_fault = 1 stay stable for 5 cycles; no new grant until the
//     handshake.
//  5. Spurious chk_resp_valid in IDLE, then a normal check with fault = 0 -> the spurious
//     pulse is ignored and rsp_fault = 0.
//  6. PMP_ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 8, checker never responds ->
//     rsp_valid with fault = 1 after 8 WAIT cycles; timeout_err = 1 until rstn is pulsed.

Source files
------------

// File: rtl/pmp_check_arbiter.sv
// -----------------------------------------------------------------------------
// pmp_check_arbiter
//   Shares one PMP checker between two requesters (port 0 = ITLB miss path,
//   port 1 = DTLB miss path). Round-robin arbitration with a single check in
//   flight; the checker result is routed back to the port that was granted.
//
// Optional feature macro: PMP_ARB_TIMEOUT_EN
//   Defined     : WAIT is bounded by TIMEOUT_CYC cycles. On expiry a fault is
//                 returned and the sticky timeout_err flag is set.
//   Not defined : WAIT has no limit and timeout_err is tied low.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   req{0,1}_valid/ready/addr/type  request channels (type 00=R 01=W 10=X)
//   rsp{0,1}_valid/ready/fault      result channels
//   chk_req_valid/ready             request handshake to the PMP checker
//   chk_addr, chk_type              registered address/type to the checker
//   chk_resp_valid/fault            one-cycle checker result pulse
//   timeout_err                     sticky timeout flag
// -----------------------------------------------------------------------------
module pmp_check_arbiter #(
  parameter int PADDR_W     = 34,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [PADDR_W-1:0] req0_addr,
  input  logic [1:0]         req0_type,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [PADDR_W-1:0] req1_addr,
  input  logic [1:0]         req1_type,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp0_fault,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic               rsp1_fault,
  output logic               chk_req_valid,
  input  logic               chk_req_ready,
  output logic [PADDR_W-1:0] chk_addr,
  output logic [1:0]         chk_type,
  input  logic               chk_resp_valid,
  input  logic               chk_resp_fault,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   rr_ptr_r;
  logic   owner_r;
  logic   fault_r;
  logic   grant0_s;
  logic   grant1_s;
  logic   accept_s;
  logic   timeout_hit_s;

  // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = ~rr_ptr_r;
      grant1_s = rr_ptr_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  // Ready is also masked by rstn so nothing looks accepted while reset is held
  assign req0_ready = rstn & (state_r == IDLE) & grant0_s;
  assign req1_ready = rstn & (state_r == IDLE) & grant1_s;
  assign accept_s   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign chk_req_valid = (state_r == ISSUE);
  assign rsp0_valid    = (state_r == RESP) & ~owner_r;
  assign rsp1_valid    = (state_r == RESP) &  owner_r;
  assign rsp0_fault    = rsp0_valid & fault_r;
  assign rsp1_fault    = rsp1_valid & fault_r;

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = ISSUE;
        else          state_next_s = IDLE;
      end
      ISSUE: begin
        if (chk_req_ready) state_next_s = WAIT;
        else               state_next_s = ISSUE;
      end
      WAIT: begin
        if (chk_resp_valid || timeout_hit_s) state_next_s = RESP;
        else                                 state_next_s = WAIT;
      end
      RESP: begin
        if ((owner_r && rsp1_ready) || (!owner_r && rsp0_ready)) state_next_s = IDLE;
        else                                                      state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, captured request, owner, round-robin pointer and latched fault
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      rr_ptr_r <= 1'b0;
      owner_r  <= 1'b0;
      fault_r  <= 1'b0;
      chk_addr <= {PADDR_W{1'b0}};
      chk_type <= 2'b00;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        if (grant1_s) begin
          chk_addr <= req1_addr;
          chk_type <= req1_type;
          owner_r  <= 1'b1;
          rr_ptr_r <= 1'b0;
        end else begin
          chk_addr <= req0_addr;
          chk_type <= req0_type;
          owner_r  <= 1'b0;
          rr_ptr_r <= 1'b1;
        end
      end
      // A real response in the expiry cycle wins over the timeout
      if (state_r == WAIT) begin
        if (chk_resp_valid)     fault_r <= chk_resp_fault;
        else if (timeout_hit_s) fault_r <= 1'b1;
      end
    end
  end

`ifdef PMP_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_r;

  assign timeout_hit_s = (state_r == WAIT) & ~chk_resp_valid &
                         (wait_cnt_r == 8'(TIMEOUT_CYC - 1));

  // WAIT cycle counter; sits at zero outside WAIT so it is clear on entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_r <= 8'd0;
    end else if (state_r == WAIT) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cyc_s;

  assign timeout_hit_s        = 1'b0;
  assign timeout_err          = 1'b0;
  assign unused_timeout_cyc_s = ^TIMEOUT_CYC;
`endif

endmodule

// File: tb/tb_pmp_check_arbiter.sv
module tb_pmp_check_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [33:0] req0_addr = 34'd0, req1_addr = 34'd0;
  logic [1:0]  req0_type = 2'd0, req1_type = 2'd0;
  logic        rsp0_valid, rsp1_valid, rsp0_fault, rsp1_fault;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic        chk_req_valid;
  logic        chk_req_ready = 1'b0;
  logic [33:0] chk_addr;
  logic [1:0]  chk_type;
  logic        chk_resp_valid = 1'b0, chk_resp_fault = 1'b0;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        port;
    logic [33:0] addr;
    logic [1:0]  typ;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  logic model_rr = 1'b0;

  always #5 clk = ~clk;

  pmp_check_arbiter #(.PADDR_W(34), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_type(req0_type),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_type(req1_type),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_fault(rsp0_fault),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_fault(rsp1_fault),
    .chk_req_valid(chk_req_valid), .chk_req_ready(chk_req_ready),
    .chk_addr(chk_addr), .chk_type(chk_type),
    .chk_resp_valid(chk_resp_valid), .chk_resp_fault(chk_resp_fault),
    .timeout_err(timeout_err)
  );

  // Plays the checker for one transaction and observes the result (no comparisons).
  // Entered and left at a falling edge. lat = cycles from first chk_req_valid to rsp valid.
  task automatic run_txn(input logic f, input int hold, input logic [1:0] drop,
                         output logic [1:0] v, output logic pf, output logic [33:0] a,
                         output logic [1:0] t, output int lat, output bit stable, output bit ok);
    int n;
    ok = 1'b1; stable = 1'b1; v = 2'b00; pf = 1'b0; a = 34'd0; t = 2'd0; lat = 0; n = 0;
    do begin @(negedge clk); n++; end while (!chk_req_valid && n < 50);
    if (!chk_req_valid) begin ok = 1'b0; return; end
    a = chk_addr; t = chk_type;
    if (drop[0]) req0_valid = 1'b0;
    if (drop[1]) req1_valid = 1'b0;
    chk_req_ready = 1'b1;
    @(negedge clk);
    chk_req_ready = 1'b0; chk_resp_valid = 1'b1; chk_resp_fault = f;
    @(negedge clk);
    chk_resp_valid = 1'b0; chk_resp_fault = 1'b0;
    lat = 2;
    while (!(rsp0_valid | rsp1_valid) && lat < 50) begin @(negedge clk); lat++; end
    if (!(rsp0_valid | rsp1_valid)) begin ok = 1'b0; return; end
    v = {rsp1_valid, rsp0_valid}; pf = rsp0_fault | rsp1_fault;
    for (int i = 0; i < hold; i++) begin
      req1_addr = req1_addr ^ 34'h1;
      @(negedge clk);
      if ({rsp1_valid, rsp0_valid} !== v || (rsp0_fault | rsp1_fault) !== pf ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 1'b0;
    end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 34'h1_2345_6780; req1_addr = 34'h0_dead_beec;
    repeat (2) @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_fault, rsp1_fault,
         chk_req_valid, timeout_err} !== 8'b0) begin
      bad++; $display("FAIL reset_outputs: got %b expected 00000000",
        {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_fault, rsp1_fault, chk_req_valid, timeout_err});
    end
    total++;
    if (chk_addr !== 34'd0 || chk_type !== 2'd0) begin
      bad++; $display("FAIL reset_chk_regs: got %h/%h expected 0/0", chk_addr, chk_type);
    end
    rstn = 1'b1; #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_first_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_rr = 1'b0;
  endtask

  task automatic test_single_port1;
    logic [1:0] v; logic pf; logic [33:0] a; logic [1:0] t; int lat; bit st, ok; exp_t e;
    req1_addr = 34'h0_8000_1000; req1_type = 2'b00; req1_valid = 1'b1;
    exp_q.push_back('{port: 1'b1, addr: 34'h0_8000_1000, typ: 2'b00, fault: 1'b0});
    model_rr = 1'b0;
    run_txn(1'b0, 0, 2'b11, v, pf, a, t, lat, st, ok);
    e = exp_q.pop_front();
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout: got %0d expected 1", ok); end
    total++; if (v !== 2'b10) begin bad++; $display("FAIL single_rsp_valid: got %b expected 10", v); end
    total++; if (pf !== e.fault) begin bad++; $display("FAIL single_fault: got %b expected %b", pf, e.fault); end
    total++; if (a !== e.addr || t !== e.typ) begin
      bad++; $display("FAIL single_chk_req: got %h/%h expected %h/%h", a, t, e.addr, e.typ);
    end
    total++; if (lat + 1 !== 3) begin bad++; $display("FAIL single_latency: got %0d expected 3", lat + 1); end
  endtask

  task automatic test_round_robin;
    logic [1:0] v; logic pf; logic [33:0] a; logic [1:0] t; int lat; bit st, ok; exp_t e;
    logic [3:0] faults;
    faults = 4'b0110;
    req0_addr = 34'h1_0000_0040; req0_type = 2'b10;
    req1_addr = 34'h2_0000_0080; req1_type = 2'b01;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.port  = model_rr;
      e.addr  = model_rr ? 34'h2_0000_0080 : 34'h1_0000_0040;
      e.typ   = model_rr ? 2'b01 : 2'b10;
      e.fault = faults[i];
      exp_q.push_back(e);
      model_rr = ~model_rr;
      run_txn(faults[i], 0, (i == 3) ? 2'b11 : 2'b00, v, pf, a, t, lat, st, ok);
      e = exp_q.pop_front();
      total++;
      if (ok !== 1'b1 || v !== (e.port ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_grant%0d: got ok=%0d rsp=%b expected rsp=%b", i, ok, v, e.port ? 2'b10 : 2'b01);
      end
      total++;
      if (a !== e.addr || t !== e.typ) begin
        bad++; $display("FAIL rr_chk_addr%0d: got %h/%h expected %h/%h", i, a, t, e.addr, e.typ);
      end
      total++;
      if (pf !== e.fault) begin bad++; $display("FAIL rr_fault%0d: got %b expected %b", i, pf, e.fault); end
    end
  endtask

  task automatic test_hold_stall;
    logic [1:0] v; logic pf; logic [33:0] a; logic [1:0] t; int lat; bit st, ok; exp_t e;
    req0_addr = 34'h0_9000_2000; req0_type = 2'b01;
    req1_addr = 34'h3_ffff_0000; req1_type = 2'b10;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_q.push_back('{port: 1'b0, addr: 34'h0_9000_2000, typ: 2'b01, fault: 1'b1});
    model_rr = 1'b1;
    run_txn(1'b1, 5, 2'b01, v, pf, a, t, lat, st, ok);
    e = exp_q.pop_front();
    total++; if (ok !== 1'b1 || v !== 2'b01) begin bad++; $display("FAIL hold_rsp_valid: got %b expected 01", v); end
    total++; if (pf !== e.fault) begin bad++; $display("FAIL hold_fault: got %b expected %b", pf, e.fault); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL hold_stable: got %0d expected 1", st); end
    total++; if (a !== e.addr || t !== e.typ) begin
      bad++; $display("FAIL hold_chk_req: got %h/%h expected %h/%h", a, t, e.addr, e.typ);
    end
    // port 1 has been stalled with a wandering address; settle it before its grant
    req1_addr = 34'h3_0000_0100; req1_type = 2'b00;
    exp_q.push_back('{port: 1'b1, addr: 34'h3_0000_0100, typ: 2'b00, fault: 1'b0});
    model_rr = 1'b0;
    run_txn(1'b0, 0, 2'b11, v, pf, a, t, lat, st, ok);
    e = exp_q.pop_front();
    total++; if (ok !== 1'b1 || v !== 2'b10) begin bad++; $display("FAIL stall_grant: got %b expected 10", v); end
    total++; if (a !== e.addr || t !== e.typ) begin
      bad++; $display("FAIL stall_chk_addr: got %h/%h expected %h/%h", a, t, e.addr, e.typ);
    end
  endtask

  task automatic test_spurious;
    logic [1:0] v; logic pf; logic [33:0] a; logic [1:0] t; int lat; bit st, ok; exp_t e;
    @(negedge clk);
    chk_resp_valid = 1'b1; chk_resp_fault = 1'b1;
    @(negedge clk);
    chk_resp_valid = 1'b0; chk_resp_fault = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp1_valid, rsp0_valid, chk_req_valid} !== 3'b000) begin
      bad++; $display("FAIL spurious_idle: got %b expected 000", {rsp1_valid, rsp0_valid, chk_req_valid});
    end
    req0_addr = 34'h0_0000_0ffc; req0_type = 2'b00; req0_valid = 1'b1;
    exp_q.push_back('{port: 1'b0, addr: 34'h0_0000_0ffc, typ: 2'b00, fault: 1'b0});
    model_rr = 1'b1;
    run_txn(1'b0, 0, 2'b11, v, pf, a, t, lat, st, ok);
    e = exp_q.pop_front();
    total++; if (ok !== 1'b1 || v !== 2'b01) begin bad++; $display("FAIL spurious_rsp: got %b expected 01", v); end
    total++; if (pf !== e.fault) begin bad++; $display("FAIL spurious_fault: got %b expected %b", pf, e.fault); end
  endtask

  task automatic test_timeout;
    int n;
    req0_addr = 34'h0_4000_0000; req0_type = 2'b00; req0_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!chk_req_valid && n < 50);
    req0_valid = 1'b0;
    chk_req_ready = 1'b1;
    @(negedge clk);
    chk_req_ready = 1'b0;
`ifdef PMP_ARB_TIMEOUT_EN
    n = 0;
    while (!(rsp0_valid | rsp1_valid) && n < 100) begin n++; @(negedge clk); end
    total++; if (n !== 8) begin bad++; $display("FAIL timeout_wait_cycles: got %0d expected 8", n); end
    total++;
    if ({rsp1_valid, rsp0_valid, rsp0_fault, timeout_err} !== 4'b0111) begin
      bad++; $display("FAIL timeout_rsp: got %b expected 0111", {rsp1_valid, rsp0_valid, rsp0_fault, timeout_err});
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
    rstn = 1'b0;
    @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end
    rstn = 1'b1;
    model_rr = 1'b0;
`else
    repeat (40) @(negedge clk);
    total++;
    if ({rsp1_valid, rsp0_valid, timeout_err} !== 3'b000) begin
      bad++; $display("FAIL unbounded_wait: got %b expected 000", {rsp1_valid, rsp0_valid, timeout_err});
    end
    chk_resp_valid = 1'b1; chk_resp_fault = 1'b0;
    @(negedge clk);
    chk_resp_valid = 1'b0;
    total++;
    if ({rsp1_valid, rsp0_valid, rsp0_fault} !== 3'b010) begin
      bad++; $display("FAIL late_rsp: got %b expected 010", {rsp1_valid, rsp0_valid, rsp0_fault});
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    model_rr = 1'b1;
`endif
  endtask

  task automatic test_reset_midflight;
    int n;
    req0_addr = 34'h0_5555_0000; req0_type = 2'b10; req0_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!chk_req_valid && n < 50);
    req0_valid = 1'b0;
    chk_req_ready = 1'b1;
    @(negedge clk);
    chk_req_ready = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk_resp_valid = 1'b1; chk_resp_fault = 1'b1;
    @(negedge clk);
    chk_resp_valid = 1'b0; chk_resp_fault = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp1_valid, rsp0_valid, chk_req_valid} !== 3'b000) begin
      bad++; $display("FAIL midreset_drop: got %b expected 000", {rsp1_valid, rsp0_valid, chk_req_valid});
    end
    model_rr = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    total++;
    if ({req0_ready, req1_ready} !== {~model_rr, model_rr}) begin
      bad++; $display("FAIL midreset_rr: got %b expected %b", {req0_ready, req1_ready}, {~model_rr, model_rr});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_port1();
    test_round_robin();
    test_hold_stall();
    test_spurious();
    test_timeout();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
